// File: rtl/inst_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_sequencer_pkg                                                         |
// | Shared opcodes, instruction/descriptor field map and FSM state type.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package inst_sequencer_pkg;

   localparam int SEQ_OPCODE_BITS = 4;
   localparam int SEQ_ADDRA_BITS  = 8;
   localparam int SEQ_ADDRB_BITS  = 8;
   localparam int SEQ_COUNT_BITS  = 16;
   localparam int SEQ_DESC_DEPTH  = 16;

   localparam logic [SEQ_OPCODE_BITS-1:0] IDLE_INST              = 4'd0;
   localparam logic [SEQ_OPCODE_BITS-1:0] AXI_TO_UB_INST         = 4'd1;
   localparam logic [SEQ_OPCODE_BITS-1:0] AXI_TO_WB_INST         = 4'd2;
   localparam logic [SEQ_OPCODE_BITS-1:0] UB_TO_DATA_FIFO_INST   = 4'd3;
   localparam logic [SEQ_OPCODE_BITS-1:0] UB_TO_WEIGHT_FIFO_INST = 4'd4;
   localparam logic [SEQ_OPCODE_BITS-1:0] MAT_MUL_INST           = 4'd5;
   localparam logic [SEQ_OPCODE_BITS-1:0] MAT_MUL_ACC_INST       = 4'd6;
   localparam logic [SEQ_OPCODE_BITS-1:0] ACC_TO_UB_INST         = 4'd7;
   localparam logic [SEQ_OPCODE_BITS-1:0] UB_TO_AXI_INST         = 4'd8;

   // Instruction word {opcode, addra, addrb} at the default widths.
   localparam int INST_ADDRB_FROM  = 0;
   localparam int INST_ADDRB_TO    = SEQ_ADDRB_BITS - 1;
   localparam int INST_ADDRA_FROM  = INST_ADDRB_TO + 1;
   localparam int INST_ADDRA_TO    = INST_ADDRA_FROM + SEQ_ADDRA_BITS - 1;
   localparam int INST_OPCODE_FROM = INST_ADDRA_TO + 1;
   localparam int INST_OPCODE_TO   = INST_OPCODE_FROM + SEQ_OPCODE_BITS - 1;

   // Descriptor LSB offsets, MSB first: sync, trail_idle, opcode, count,
   // addra_base, addra_stride, addrb_base, addrb_stride.
   localparam int DESC_BSTRIDE_LSB = 0;
   localparam int DESC_BBASE_LSB   = DESC_BSTRIDE_LSB + SEQ_ADDRB_BITS;
   localparam int DESC_ASTRIDE_LSB = DESC_BBASE_LSB + SEQ_ADDRB_BITS;
   localparam int DESC_ABASE_LSB   = DESC_ASTRIDE_LSB + SEQ_ADDRA_BITS;
   localparam int DESC_COUNT_LSB   = DESC_ABASE_LSB + SEQ_ADDRA_BITS;
   localparam int DESC_OPCODE_LSB  = DESC_COUNT_LSB + SEQ_COUNT_BITS;
   localparam int DESC_TRAIL_BIT   = DESC_OPCODE_LSB + SEQ_OPCODE_BITS;
   localparam int DESC_SYNC_BIT    = DESC_TRAIL_BIT + 1;
   localparam int DESC_BITS        = DESC_SYNC_BIT + 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_WAIT_HI  = 3'd2,
      S_WAIT_LO  = 3'd3,
      S_SYNC     = 3'd4,
      S_TRAIL_HI = 3'd5,
      S_TRAIL_LO = 3'd6,
      S_DONE     = 3'd7
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_sequencer_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_addr_gen                                                               |
// | Base/stride accumulator for one instruction address field.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_addr_gen #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [ADDR_BITS-1:0] base,
   input  logic [ADDR_BITS-1:0] stride,
   output logic [ADDR_BITS-1:0] addr_next
);

   logic [ADDR_BITS-1:0] addr_q;
   logic [ADDR_BITS-1:0] addr_d;

   // Wrapping add: a two's-complement stride walks downward naturally.
   always_comb begin
      addr_next = addr_q + stride;
      addr_d    = addr_q;
      if (load) begin
         addr_d = base;
      end else if (step) begin
         addr_d = addr_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_sequencer                                                             |
// | Replays loop descriptors as SYSTOLIC_ARRAY instructions via flag handshake.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter  int OPCODE_BITS = SEQ_OPCODE_BITS,
   parameter  int ADDRA_BITS  = SEQ_ADDRA_BITS,
   parameter  int ADDRB_BITS  = SEQ_ADDRB_BITS,
   parameter  int COUNT_BITS  = SEQ_COUNT_BITS,
   parameter  int DESC_DEPTH  = SEQ_DESC_DEPTH,
   parameter  int IDLE_OPCODE = 0,
   localparam int IDX_BITS    = $clog2(DESC_DEPTH),
   localparam int INST_BITS   = OPCODE_BITS + ADDRA_BITS + ADDRB_BITS,
   localparam int DESC_W      = 2 + OPCODE_BITS + COUNT_BITS + 2*ADDRA_BITS + 2*ADDRB_BITS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 desc_wr_en,
   input  logic [IDX_BITS-1:0]  desc_wr_addr,
   input  logic [DESC_W-1:0]    desc_wr_data,
   input  logic                 start,
   input  logic [IDX_BITS:0]    desc_num,
   input  logic                 abort,
   input  logic                 flag,
   input  logic                 idle_flag,
   output logic [INST_BITS-1:0] instruction,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic [IDX_BITS-1:0]  cur_desc
);

   localparam int F_BSTR  = 0;
   localparam int F_BBASE = F_BSTR + ADDRB_BITS;
   localparam int F_ASTR  = F_BBASE + ADDRB_BITS;
   localparam int F_ABASE = F_ASTR + ADDRA_BITS;
   localparam int F_CNT   = F_ABASE + ADDRA_BITS;
   localparam int F_OP    = F_CNT + COUNT_BITS;
   localparam int F_TRAIL = F_OP + OPCODE_BITS;
   localparam int F_SYNC  = F_TRAIL + 1;

   localparam logic [INST_BITS-1:0] IDLE_WORD =
      {OPCODE_BITS'(IDLE_OPCODE), {(ADDRA_BITS + ADDRB_BITS){1'b0}}};

   logic [DESC_W-1:0] table_q [DESC_DEPTH];

   seq_state_e             state_q, state_d;
   logic [IDX_BITS-1:0]    cur_desc_q, cur_desc_d;
   logic [IDX_BITS:0]      desc_num_q, desc_num_d;
   logic [COUNT_BITS-1:0]  i_q, i_d;
   logic                   sync_q, sync_d;
   logic                   trail_q, trail_d;
   logic [OPCODE_BITS-1:0] op_q, op_d;
   logic [COUNT_BITS-1:0]  count_q, count_d;
   logic [ADDRA_BITS-1:0]  astride_q, astride_d;
   logic [ADDRB_BITS-1:0]  bstride_q, bstride_d;
   logic [INST_BITS-1:0]   instruction_q, instruction_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   aborted_q, aborted_d;

   logic [DESC_W-1:0]      rd;
   logic                   rd_sync, rd_trail;
   logic [OPCODE_BITS-1:0] rd_op;
   logic [COUNT_BITS-1:0]  rd_count;
   logic [ADDRA_BITS-1:0]  rd_abase, rd_astride;
   logic [ADDRB_BITS-1:0]  rd_bbase, rd_bstride;
   logic [ADDRA_BITS-1:0]  a_next;
   logic [ADDRB_BITS-1:0]  b_next;
   logic [COUNT_BITS-1:0]  i_inc;
   logic [IDX_BITS:0]      next_idx;
   logic                   last_desc;
   logic                   gen_load, gen_step, accept, advance;

   always_ff @(posedge clk) begin
      if (desc_wr_en && !busy_q) begin
         table_q[desc_wr_addr] <= desc_wr_data;
      end
   end

   assign rd         = table_q[cur_desc_q];
   assign rd_sync    = rd[F_SYNC];
   assign rd_trail   = rd[F_TRAIL];
   assign rd_op      = rd[F_OP +: OPCODE_BITS];
   assign rd_count   = rd[F_CNT +: COUNT_BITS];
   assign rd_abase   = rd[F_ABASE +: ADDRA_BITS];
   assign rd_astride = rd[F_ASTR +: ADDRA_BITS];
   assign rd_bbase   = rd[F_BBASE +: ADDRB_BITS];
   assign rd_bstride = rd[F_BSTR +: ADDRB_BITS];

   assign i_inc     = i_q + 1'b1;
   assign next_idx  = {1'b0, cur_desc_q} + 1'b1;
   assign last_desc = (next_idx >= desc_num_q);

   seq_addr_gen #(.ADDR_BITS(ADDRA_BITS)) u_addr_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (gen_load),
      .step      (gen_step),
      .base      (rd_abase),
      .stride    (astride_q),
      .addr_next (a_next)
   );

   seq_addr_gen #(.ADDR_BITS(ADDRB_BITS)) u_addr_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (gen_load),
      .step      (gen_step),
      .base      (rd_bbase),
      .stride    (bstride_q),
      .addr_next (b_next)
   );

   always_comb begin
      state_d       = state_q;
      cur_desc_d    = cur_desc_q;
      desc_num_d    = desc_num_q;
      i_d           = i_q;
      sync_d        = sync_q;
      trail_d       = trail_q;
      op_d          = op_q;
      count_d       = count_q;
      astride_d     = astride_q;
      bstride_d     = bstride_q;
      instruction_d = instruction_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      aborted_d     = 1'b0;
      gen_load      = 1'b0;
      gen_step      = 1'b0;
      accept        = 1'b0;
      advance       = 1'b0;

      if (abort && (state_q != S_IDLE)) begin
         state_d       = S_IDLE;
         instruction_d = IDLE_WORD;
         aborted_d     = 1'b1;
         busy_d        = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               instruction_d = IDLE_WORD;
               if (start) begin
                  cur_desc_d = '0;
                  desc_num_d = desc_num;
                  busy_d     = 1'b1;
                  state_d    = (desc_num == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               i_d       = '0;
               sync_d    = rd_sync;
               trail_d   = rd_trail;
               op_d      = rd_op;
               count_d   = rd_count;
               astride_d = rd_astride;
               bstride_d = rd_bstride;
               if (rd_count == '0) begin
                  advance = 1'b1;
               end else begin
                  gen_load      = 1'b1;
                  instruction_d = {rd_op, rd_abase, rd_bbase};
                  state_d       = S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               if (flag) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!flag) begin
                  if (sync_q && (i_q == '0)) state_d = S_SYNC;
                  else                       accept  = 1'b1;
               end
            end
            S_SYNC: begin
               if (!idle_flag) accept = 1'b1;
            end
            S_TRAIL_HI: begin
               if (flag) state_d = S_TRAIL_LO;
            end
            S_TRAIL_LO: begin
               if (!flag) advance = 1'b1;
            end
            S_DONE: begin
               instruction_d = IDLE_WORD;
               done_d        = 1'b1;
               busy_d        = 1'b0;
               state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         if (accept) begin
            i_d = i_inc;
            if (i_inc < count_q) begin
               gen_step      = 1'b1;
               instruction_d = {op_q, a_next, b_next};
               state_d       = S_WAIT_HI;
            end else if (trail_q) begin
               instruction_d = IDLE_WORD;
               state_d       = S_TRAIL_HI;
            end else begin
               advance = 1'b1;
            end
         end

         // The last accepted instruction is held while the next descriptor loads.
         if (advance) begin
            if (last_desc) begin
               instruction_d = IDLE_WORD;
               state_d       = S_DONE;
            end else begin
               cur_desc_d = cur_desc_q + 1'b1;
               state_d    = S_LOAD;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cur_desc_q    <= '0;
         desc_num_q    <= '0;
         i_q           <= '0;
         sync_q        <= 1'b0;
         trail_q       <= 1'b0;
         op_q          <= '0;
         count_q       <= '0;
         astride_q     <= '0;
         bstride_q     <= '0;
         instruction_q <= IDLE_WORD;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_desc_q    <= cur_desc_d;
         desc_num_q    <= desc_num_d;
         i_q           <= i_d;
         sync_q        <= sync_d;
         trail_q       <= trail_d;
         op_q          <= op_d;
         count_q       <= count_d;
         astride_q     <= astride_d;
         bstride_q     <= bstride_d;
         instruction_q <= instruction_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
      end
   end

   assign instruction = instruction_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign cur_desc    = cur_desc_q;

endmodule
`default_nettype wire

// File: doc/inst_sequencer.md
# inst_sequencer

Programmable instruction sequencer that drives the `instruction` port of `SYSTOLIC_ARRAY`. It replays a table of loop descriptors; each descriptor covers one opcode, an iteration count and strided ADDRA/ADDRB generation. It steps through them using the array's `flag`/`idle_flag` handshake, so the host no longer issues instructions one at a time. It sits between the host/control register file and `SYSTOLIC_ARRAY`.

## Interface
Parameters:
- OPCODE_BITS, 4: opcode field width.
- ADDRA_BITS, 8: ADDRA field width.
- ADDRB_BITS, 8: ADDRB field width.
- COUNT_BITS, 16: iteration-count width.
- DESC_DEPTH, 16: descriptor table entries (power of 2).
- IDLE_OPCODE, 0: opcode value of IDLE_INST.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous active-low reset.
- desc_wr_en, in, 1: write a descriptor. Ignored while busy.
- desc_wr_addr, in, log2(DESC_DEPTH): table index.
- desc_wr_data, in, DESC_BITS: {sync, trail_idle, opcode, count, addra_base, addra_stride, addrb_base, addrb_stride}, MSB first.
- start, in, 1: one-cycle pulse that begins execution at entry 0. Ignored while busy.
- desc_num, in, log2(DESC_DEPTH)+1: number of descriptors to run, sampled on start.
- abort, in, 1: synchronous abort.
- flag, in, 1: array instruction-accept flag, synchronous to clk.
- idle_flag, in, 1: array idle indicator.
- instruction, out, OPCODE_BITS+ADDRA_BITS+ADDRB_BITS: {opcode, addra, addrb}, registered.
- busy, out, 1: sequence in progress.
- done, out, 1: one-cycle pulse at normal completion.
- aborted, out, 1: one-cycle pulse after an abort.
- cur_desc, out, log2(DESC_DEPTH): index of the executing descriptor.

## Operation
- States: S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_SYNC, S_TRAIL_HI, S_TRAIL_LO, S_DONE.
- S_IDLE: instruction = {IDLE_OPCODE, 0, 0}. start with desc_num > 0 → S_LOAD. start with desc_num = 0 → S_DONE.
- S_LOAD: read the descriptor at cur_desc and clear the iteration counter i.
  - count = 0: skip; go to the next descriptor, or S_DONE after the last.
  - Otherwise: drive {opcode, addra_base, addrb_base} and go to S_WAIT_HI.
- S_WAIT_HI → S_WAIT_LO when flag = 1.
- S_WAIT_LO → on flag = 0 the instruction is accepted:
  - If sync = 1 and i = 0, go to S_SYNC.
  - Otherwise increment i. If i < count, drive the next address pair and return to S_WAIT_HI. If the descriptor is finished, go to S_TRAIL_HI when trail_idle = 1, else to the next S_LOAD or S_DONE.
- S_SYNC: wait for idle_flag = 0, then continue as for an accepted instruction.
- S_TRAIL_HI/LO: drive the IDLE opcode with addresses 0 and perform one full flag high→low handshake.
- Address arithmetic:
  - addra = addra_base + i·addra_stride, modulo 2^ADDRA_BITS. Stride is two's complement.
  - ADDRB uses the same rule with its own base and stride.
  - Computed incrementally with an accumulator; no multiplier.
- S_DONE: pulse done for one cycle, drive IDLE, return to S_IDLE.
- abort, in any state other than S_IDLE:
  - Next edge: instruction becomes IDLE, aborted pulses, busy clears, state goes to S_IDLE.
  - Abort takes priority over a flag edge in the same cycle.
- desc_wr_en while busy: no write. The table is unchanged.

## Timing
- Reset values: instruction = {IDLE_OPCODE, 0, 0}; busy, done, aborted = 0; cur_desc = 0; state S_IDLE. Reset mid-sequence behaves the same. The descriptor table contents are not reset.
- start at edge 0: busy = 1 after edge 0; first instruction is valid after edge 1 (S_LOAD is one cycle).
- Flag-low sampled at edge k: the next instruction is valid after edge k. An instruction stays stable from issue until its accepting edge.
- A flag pulse that is high for one cycle is accepted: WAIT_HI sees the high, WAIT_LO sees the following low.
- done is asserted one cycle after the final accepting edge; busy deasserts on the same edge.

## Structure
- Shared package:
  - opcode localparams: IDLE_INST, AXI_TO_UB_INST, AXI_TO_WB_INST, UB_TO_DATA_FIFO_INST, UB_TO_WEIGHT_FIFO_INST, MAT_MUL_INST, MAT_MUL_ACC_INST, ACC_TO_UB_INST, UB_TO_AXI_INST.
  - instruction field FROM/TO bit positions.
  - descriptor field offsets and DESC_BITS.
- One sub-module, `seq_addr_gen`: base/stride accumulator for one address field, instantiated twice.
- The descriptor table is a register array (distributed RAM) inside the top module.

## Test plan
- Descriptor {AXI_TO_UB, count 64, A 0/+1, B 0/+4, sync=1}: 64 instructions, last = (63, 252). The second instruction waits for idle_flag = 0.
- Descriptor {AXI_TO_WB, count 64, A 0/+1, B 251/−4}: last ADDRB = 255 (wrap). No address glitches between handshakes.
- Three descriptors (MAT_MUL ×16, count 0, ACC_TO_UB ×16 with A base 64, trail_idle=1): the middle descriptor is skipped, one IDLE follows the last, done pulses once.
- abort asserted at iteration 5 while flag = 0→1 in the same cycle: instruction becomes IDLE next cycle, aborted pulses, no further handshakes are consumed.
- reset_n pulsed low mid-sequence: all outputs return to reset values immediately. A later start with desc_num = 1 reruns from entry 0.
- start with desc_num = 0, and desc_wr_en while busy: done pulses two cycles after start; the table is unchanged on readback-by-execution.
